// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the MEM stage (core) and a DMA/debug port.
// Core has priority; a starvation counter forces a one-cycle DMA grant.
//
// Ports:
//   clk, reset (async, active-low)
//   core_req/we/addr/wdata -> core_rdata, core_stall
//   dma_valid/we/addr/wdata -> dma_ready, dma_rvalid, dma_rdata
//   mem_we/addr/wdata -> data memory, mem_rdata <- data memory (comb read)
module dmem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dma_valid,
  output logic          dma_ready,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {
    S_CORE,
    S_DMA
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] starveCnt;
  logic          starveFull;
  logic          dmaRead;

  assign starveFull = (starveCnt == LIMIT);
  assign core_rdata = mem_rdata;
  assign dmaRead    = (state == S_DMA) & dma_valid & ~dma_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CORE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    mem_we     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    core_stall = 1'b0;
    dma_ready  = 1'b0;
    unique case (state)
      S_CORE: begin
        mem_we = core_req & core_we;
        if (dma_valid & (~core_req | starveFull)) begin
          stateNext = S_DMA;
        end
      end
      S_DMA: begin
        mem_we     = dma_valid & dma_we;
        mem_addr   = dma_addr;
        mem_wdata  = dma_wdata;
        dma_ready  = 1'b1;
        core_stall = core_req;
        stateNext  = S_CORE;
      end
    endcase
    // Reset must kill any write in flight, even mid-grant.
    if (!reset) begin
      mem_we     = 1'b0;
      dma_ready  = 1'b0;
      core_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (!dma_valid || state == S_DMA) begin
      starveCnt <= '0;
    end else if (core_req && !starveFull) begin
      starveCnt <= starveCnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dmaRead;
      if (dmaRead) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter.
// DMA read data is checked through an expected-value queue.
module tb_dmem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_stall;
  logic          dma_valid, dma_ready, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] expQ [$];
  int nChecks = 0;
  int nFails  = 0;

  dmem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Scoreboard: every rvalid pulse pops one expected read value.
  always @(negedge clk) begin
    if (reset && dma_rvalid) begin
      nChecks++;
      if (expQ.size() == 0) begin
        $display("FAIL rvalid_unexpected: got rdata %h, want no rvalid",
                 dma_rdata);
        nFails++;
      end else begin
        logic [DW-1:0] e;
        e = expQ.pop_front();
        if (dma_rdata !== e) begin
          $display("FAIL sb_rdata: got %h want %h", dma_rdata, e);
          nFails++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_valid = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle();
    core_req = 1; core_we = 1; dma_valid = 1; dma_we = 1;
    tick();
    @(negedge clk);
    if (mem_we !== 1'b0) begin
      $display("FAIL rst_mem_we: got %b want 0", mem_we); nFails++;
    end
    nChecks++;
    if (dma_ready !== 1'b0) begin
      $display("FAIL rst_ready: got %b want 0", dma_ready); nFails++;
    end
    nChecks++;
    if (core_stall !== 1'b0) begin
      $display("FAIL rst_stall: got %b want 0", core_stall); nFails++;
    end
    nChecks++;
    if (dma_rvalid !== 1'b0 || dma_rdata !== '0) begin
      $display("FAIL rst_rvalid: got %b/%h want 0/0",
               dma_rvalid, dma_rdata); nFails++;
    end
    nChecks++;
    if (dut.starveCnt !== 3'd0) begin
      $display("FAIL rst_cnt: got %0d want 0", dut.starveCnt); nFails++;
    end
    nChecks++;
    tick();
    idle();
    reset = 1;
    tick();
  endtask

  task automatic test_dma_write();
    dma_valid = 1; dma_we = 1;
    dma_addr = 32'h40; dma_wdata = 32'hDEADBEEF;
    @(negedge clk);
    if (dma_ready !== 1'b0) begin
      $display("FAIL wr_c0_ready: got %b want 0", dma_ready); nFails++;
    end
    nChecks++;
    tick();
    @(negedge clk);
    if (dma_ready !== 1'b1 || mem_we !== 1'b1) begin
      $display("FAIL wr_c1_grant: got ready %b we %b want 1 1",
               dma_ready, mem_we); nFails++;
    end
    nChecks++;
    if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
      $display("FAIL wr_c1_bus: got %h/%h want 40/deadbeef",
               mem_addr, mem_wdata); nFails++;
    end
    nChecks++;
    tick();
    idle();
    core_req = 1; core_addr = 32'h40;
    @(negedge clk);
    if (core_rdata !== 32'hDEADBEEF || core_stall !== 1'b0) begin
      $display("FAIL wr_core_load: got %h stall %b want deadbeef 0",
               core_rdata, core_stall); nFails++;
    end
    nChecks++;
    tick();
    idle();
  endtask

  task automatic test_dma_read();
    dma_valid = 1; dma_we = 0; dma_addr = 32'h40;
    expQ.push_back(32'hDEADBEEF);
    tick();
    @(negedge clk);
    if (dma_ready !== 1'b1 || mem_we !== 1'b0) begin
      $display("FAIL rd_c1: got ready %b we %b want 1 0",
               dma_ready, mem_we); nFails++;
    end
    nChecks++;
    tick();
    idle();
    @(negedge clk);
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hDEADBEEF) begin
      $display("FAIL rd_c2: got rvalid %b data %h want 1 deadbeef",
               dma_rvalid, dma_rdata); nFails++;
    end
    nChecks++;
    tick();
    @(negedge clk);
    if (dma_rvalid !== 1'b0) begin
      $display("FAIL rd_c3: got rvalid %b want 0", dma_rvalid); nFails++;
    end
    nChecks++;
    tick();
  endtask

  task automatic test_starvation();
    int expCnt;
    logic expGrant;
    for (int k = 0; k <= 6; k++) begin
      if (k == 0) begin
        core_req = 1; core_we = 0; core_addr = 32'h0;
        dma_valid = 1; dma_we = 1;
        dma_addr = 32'h44; dma_wdata = 32'h55;
      end else begin
        tick();
      end
      if (k == 6) dma_valid = 0;
      @(negedge clk);
      expGrant = (k == LIM + 1);
      expCnt = (k == 6) ? 0 : ((k < LIM) ? k : LIM);
      if (dma_ready !== expGrant || core_stall !== expGrant) begin
        $display("FAIL starve_grant c%0d: got ready %b stall %b want %b",
                 k, dma_ready, core_stall, expGrant); nFails++;
      end
      nChecks++;
      if (dut.starveCnt !== 3'(expCnt)) begin
        $display("FAIL starve_cnt c%0d: got %0d want %0d",
                 k, dut.starveCnt, expCnt); nFails++;
      end
      nChecks++;
    end
    if (mem[17] !== 32'h55) begin
      $display("FAIL starve_mem: got %h want 55", mem[17]); nFails++;
    end
    nChecks++;
    tick();
    idle();
  endtask

  task automatic test_store_conflict();
    dma_valid = 1; dma_we = 1;
    dma_addr = 32'h80; dma_wdata = 32'h22;
    tick();
    core_req = 1; core_we = 1;
    core_addr = 32'h80; core_wdata = 32'h11;
    @(negedge clk);
    if (core_stall !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h22) begin
      $display("FAIL sc_c1: got stall %b we %b wd %h want 1 1 22",
               core_stall, mem_we, mem_wdata); nFails++;
    end
    nChecks++;
    tick();
    dma_valid = 0;
    @(negedge clk);
    if (mem[32] !== 32'h22) begin
      $display("FAIL sc_dma_first: got %h want 22", mem[32]); nFails++;
    end
    nChecks++;
    if (core_stall !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h11) begin
      $display("FAIL sc_c2: got stall %b we %b wd %h want 0 1 11",
               core_stall, mem_we, mem_wdata); nFails++;
    end
    nChecks++;
    tick();
    idle();
    @(negedge clk);
    if (mem[32] !== 32'h11) begin
      $display("FAIL sc_final: got %h want 11", mem[32]); nFails++;
    end
    nChecks++;
    tick();
  endtask

  task automatic test_dma_drop();
    for (int k = 0; k <= 4; k++) begin
      if (k == 0) begin
        core_req = 1; core_we = 0; core_addr = 32'h0;
        dma_valid = 1; dma_we = 1;
        dma_addr = 32'h90; dma_wdata = 32'h77;
      end else begin
        tick();
      end
      if (k == 3) dma_valid = 0;
      @(negedge clk);
      if (dma_ready !== 1'b0 || core_stall !== 1'b0) begin
        $display("FAIL drop_c%0d: got ready %b stall %b want 0 0",
                 k, dma_ready, core_stall); nFails++;
      end
      nChecks++;
    end
    if (dut.starveCnt !== 3'd0) begin
      $display("FAIL drop_cnt: got %0d want 0", dut.starveCnt); nFails++;
    end
    nChecks++;
    if (mem[36] !== 32'h0) begin
      $display("FAIL drop_mem: got %h want 0", mem[36]); nFails++;
    end
    nChecks++;
    tick();
    idle();
  endtask

  task automatic test_reset_mid_dma();
    dma_valid = 1; dma_we = 1;
    dma_addr = 32'hA0; dma_wdata = 32'h33;
    tick();
    core_req = 1; core_we = 0; core_addr = 32'h0;
    @(negedge clk);
    if (dma_ready !== 1'b1 || mem_we !== 1'b1 || core_stall !== 1'b1) begin
      $display("FAIL rm_pre: got ready %b we %b stall %b want 1 1 1",
               dma_ready, mem_we, core_stall); nFails++;
    end
    nChecks++;
    #1 reset = 0;
    #1;
    if (mem_we !== 1'b0 || dma_ready !== 1'b0 || core_stall !== 1'b0) begin
      $display("FAIL rm_async: got we %b ready %b stall %b want 0 0 0",
               mem_we, dma_ready, core_stall); nFails++;
    end
    nChecks++;
    tick();
    reset = 1;
    idle();
    @(negedge clk);
    if (dma_ready !== 1'b0 || dma_rvalid !== 1'b0) begin
      $display("FAIL rm_post: got ready %b rvalid %b want 0 0",
               dma_ready, dma_rvalid); nFails++;
    end
    nChecks++;
    tick();
    @(negedge clk);
    if (dma_rvalid !== 1'b0 || mem[40] !== 32'h0) begin
      $display("FAIL rm_mem: got rvalid %b mem %h want 0 0",
               dma_rvalid, mem[40]); nFails++;
    end
    nChecks++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_dma_write();
    test_dma_read();
    test_starvation();
    test_store_conflict();
    test_dma_drop();
    test_reset_mid_dma();
    nChecks++;
    if (expQ.size() != 0) begin
      $display("FAIL sb_leftover: got %0d pending want 0", expQ.size());
      nFails++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
